// File: rtl/piradip_axi4_mgr.sv
// piradip_axi4_mgr: turns one command into one AXI4 INCR burst, with a single transaction in flight.
// Latency: AW/AR one cycle after command accept; W/R beats pass through combinationally; done_valid one cycle after the last B/R handshake.
// Backpressure: cmd_ready only while idle; wr/rd stream ready/valid are wired straight to the W/R channels during the data phase.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   cmd_*                : command handshake (write flag, aligned byte address, AxLEN)
//   wr_t*                : write data stream feeding the W channel
//   rd_t*                : read data stream fed from the R channel
//   done_valid/done_resp : one-cycle completion pulse with the worst response of the burst
//   m_axi_*              : AXI4 manager port (ID 0 only, INCR bursts only)

module piradip_axi4_mgr #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 1
) (
    input  logic                      clk,
    input  logic                      resetn,

    // command
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,

    // write data stream
    input  logic [DATA_WIDTH-1:0]     wr_tdata,
    input  logic                      wr_tvalid,
    output logic                      wr_tready,

    // read data stream
    output logic [DATA_WIDTH-1:0]     rd_tdata,
    output logic                      rd_tvalid,
    input  logic                      rd_tready,
    output logic                      rd_tlast,

    // completion
    output logic                      done_valid,
    output logic [1:0]                done_resp,

    // AXI4 write address channel
    output logic [0:0]                m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    // AXI4 write data channel
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    // AXI4 write response channel
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    // AXI4 read address channel
    output logic [0:0]                m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    // Elaboration-time parameter guards
    if (MAX_OUTSTANDING != 1) begin : g_bad_outstanding
        $error("piradip_axi4_mgr: MAX_OUTSTANDING must be 1");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("piradip_axi4_mgr: DATA_WIDTH must be 32 or 64");
    end

    localparam logic [2:0] AXSIZE    = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INC = 2'b01;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t                  state_q, state_d;
    logic                    live_q;               // low until the first edge after reset release
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              beat_q, beat_d;
    logic [1:0]              err_q, err_d;         // worst RRESP seen so far in this burst
    logic                    done_q, done_d;
    logic [1:0]              done_resp_q, done_resp_d;

    logic                    last_beat;
    logic [1:0]              resp_max;

    assign last_beat = (beat_q == len_q);
    // Response codes are ordered OKAY < EXOKAY < SLVERR < DECERR, so a plain max keeps errors sticky.
    assign resp_max  = (m_axi_rresp > err_q) ? m_axi_rresp : err_q;

    // Address/control fields come straight from the command registers, so they
    // stay stable for as long as AxVALID waits on AxREADY.
    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = BURST_INC;
    assign m_axi_awcache = 4'b0000;
    assign m_axi_awprot  = 3'b000;

    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = BURST_INC;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;

    assign m_axi_wdata   = wr_tdata;
    assign m_axi_wstrb   = '1;
    assign rd_tdata      = m_axi_rdata;

    assign done_valid    = done_q;
    assign done_resp     = done_resp_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            live_q      <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        err_d         = err_q;
        done_d        = 1'b0;
        done_resp_d   = done_resp_q;

        cmd_ready     = 1'b0;
        wr_tready     = 1'b0;
        rd_tvalid     = 1'b0;
        rd_tlast      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                // Hold off while the completion pulse is out so a new command
                // is never accepted in the same cycle as done_valid.
                cmd_ready = live_q && !done_q;
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    beat_d  = '0;
                    err_d   = '0;
                    state_d = cmd_write ? WADDR : RADDR;
                end
            end

            WADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = WDATA;
                end
            end

            WDATA: begin
                m_axi_wvalid = wr_tvalid;
                wr_tready    = m_axi_wready;
                m_axi_wlast  = last_beat;
                if (wr_tvalid && m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = WRESP;
                    end
                end
            end

            WRESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    done_d      = 1'b1;
                    done_resp_d = m_axi_bresp;
                    state_d     = IDLE;
                end
            end

            RADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = RDATA;
                end
            end

            RDATA: begin
                rd_tvalid    = m_axi_rvalid;
                m_axi_rready = rd_tready;
                rd_tlast     = m_axi_rlast;
                if (m_axi_rvalid && rd_tready) begin
                    beat_d = beat_q + 8'd1;
                    err_d  = resp_max;
                    // The burst ends on RLAST or on the final expected beat,
                    // whichever comes first; disagreement between the two is a
                    // protocol violation reported as SLVERR.
                    if (m_axi_rlast || last_beat) begin
                        done_d      = 1'b1;
                        done_resp_d = (m_axi_rlast != last_beat) ? RESP_SLV : resp_max;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piradip_axi4_mgr.sv
// tb_piradip_axi4_mgr: randomized bench for piradip_axi4_mgr with a transaction-level subordinate model.
// Latency: checks AW/AR phase entry, beat pass-through and the one-cycle-late done pulse.
// Backpressure: random AW/AR/W/B/R readiness plus a fixed every-third-cycle rd_tready pattern.

module tb_piradip_axi4_mgr;

    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk;
    logic            resetn;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [DW-1:0]   wr_tdata;
    logic            wr_tvalid, wr_tready;
    logic [DW-1:0]   rd_tdata;
    logic            rd_tvalid, rd_tready, rd_tlast;
    logic            done_valid;
    logic [1:0]      done_resp;

    logic [0:0]      awid, arid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize, awprot, arprot;
    logic [1:0]      awburst, arburst;
    logic [3:0]      awcache, arcache;
    logic            awvalid, awready, arvalid, arready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid, wready;
    logic [1:0]      bresp, rresp;
    logic            bvalid, bready;
    logic            rlast, rvalid, rready;

    int              n_vec = 0;
    int              n_err = 0;

    logic [DW-1:0]   g_wdata [0:255];
    logic [DW-1:0]   g_rdata [0:255];
    logic [1:0]      g_rresp [0:255];

    piradip_axi4_mgr #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_tdata      (wr_tdata),
        .wr_tvalid     (wr_tvalid),
        .wr_tready     (wr_tready),
        .rd_tdata      (rd_tdata),
        .rd_tvalid     (rd_tvalid),
        .rd_tready     (rd_tready),
        .rd_tlast      (rd_tlast),
        .done_valid    (done_valid),
        .done_resp     (done_resp),
        .m_axi_awid    (awid),
        .m_axi_awaddr  (awaddr),
        .m_axi_awlen   (awlen),
        .m_axi_awsize  (awsize),
        .m_axi_awburst (awburst),
        .m_axi_awcache (awcache),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wlast   (wlast),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_arid    (arid),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arcache (arcache),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_tdata  = '0;   wr_tvalid = 1'b0; rd_tready = 1'b0;
        awready   = 1'b0; wready    = 1'b0; bvalid    = 1'b0; bresp = 2'b00;
        arready   = 1'b0; rvalid    = 1'b0; rdata     = '0;   rresp = 2'b00; rlast = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            int r;
            g_wdata[i] = $urandom();
            g_rdata[i] = $urandom();
            r = $urandom_range(0, 9);
            g_rresp[i] = (r < 6) ? 2'b00 : 2'(r - 6);
        end
    endtask

    // One command end to end. rlast_at is the read beat carrying RLAST
    // (> len means the subordinate never sends it); rst_beat >= 0 pulls reset
    // once that many write beats have gone through.
    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input int len, input int stall,
                          input int rlast_at, input logic [1:0] bresp_v, input bit bp, input int rst_beat);
        bit         accepted = 0, aw_done = 0, b_done = 0, ar_done = 0, r_done = 0;
        bit         done_next = 0, done_exp, post = 0, fin = 0, rst_hit = 0;
        bit         in_waddr, in_wdata, in_wresp, in_raddr, in_rdata;
        int         w_cnt = 0, r_cnt = 0, aw_wait = 0, aw_hs = 0, ar_hs = 0, cyc = 0, n_rsend;
        logic [1:0] exp_resp;

        n_rsend = (rlast_at <= len) ? rlast_at + 1 : len + 1;
        if (wr) begin
            exp_resp = bresp_v;
        end else if (rlast_at != len) begin
            exp_resp = 2'b10;
        end else begin
            exp_resp = 2'b00;
            for (int i = 0; i <= len; i++)
                if (g_rresp[i] > exp_resp) exp_resp = g_rresp[i];
        end

        while (!fin && cyc < 4000) begin
            in_waddr  = wr && accepted && !aw_done;
            in_wdata  = wr && aw_done && (w_cnt <= len);
            in_wresp  = wr && aw_done && (w_cnt > len) && !b_done;
            in_raddr  = !wr && accepted && !ar_done;
            in_rdata  = !wr && ar_done && !r_done;
            done_exp  = done_next;
            done_next = 0;

            if (wr && rst_beat >= 0 && w_cnt >= rst_beat) begin
                wr_tvalid = 1'b1; wready = 1'b1; awready = 1'b1; bvalid = 1'b1;
                #1;
                resetn = 1'b0;
                #1;
                chk("rst_async_outs", 64'({awvalid, wvalid, bready, arvalid, rready, cmd_ready,
                                          wr_tready, rd_tvalid, done_valid}), 64'(0));
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("rst_no_done", 64'(done_valid), 64'(0));
                    chk("rst_cmd_ready_low", 64'(cmd_ready), 64'(0));
                end
                @(negedge clk);
                resetn = 1'b1;
                drive_idle();
                #1;
                chk("rst_ready_before_edge", 64'(cmd_ready), 64'(0));
                @(posedge clk); #1;
                chk("rst_ready_after_edge", 64'(cmd_ready), 64'(1));
                chk("rst_no_done_after", 64'(done_valid), 64'(0));
                rst_hit = 1;
                fin     = 1;
            end else begin
                cmd_valid = !accepted;
                cmd_write = wr;
                cmd_addr  = addr;
                cmd_len   = 8'(len);
                awready   = (in_waddr && aw_wait < stall) ? 1'b0 : 1'($urandom_range(0, 1));
                wr_tvalid = ($urandom_range(0, 3) != 0) && (w_cnt <= len);
                wr_tdata  = g_wdata[w_cnt % 256];
                wready    = ($urandom_range(0, 3) != 0);
                bvalid    = in_wresp && ($urandom_range(0, 1) == 1);
                bresp     = bresp_v;
                arready   = 1'($urandom_range(0, 1));
                rvalid    = in_rdata && (r_cnt < n_rsend) && ($urandom_range(0, 3) != 0);
                rdata     = g_rdata[r_cnt % 256];
                rresp     = g_rresp[r_cnt % 256];
                rlast     = (r_cnt == rlast_at);
                rd_tready = bp ? (cyc % 3 != 2) : ($urandom_range(0, 3) != 0);
                #1;

                chk("cmd_ready", 64'(cmd_ready), 64'(!accepted || post));
                chk("done_valid", 64'(done_valid), 64'(done_exp));
                if (done_exp) begin
                    chk("done_resp", 64'(done_resp), 64'(exp_resp));
                    post = 1;
                end else if (post) begin
                    fin = 1;
                end

                chk("awvalid", 64'(awvalid), 64'(in_waddr));
                if (in_waddr) begin
                    chk("awaddr", 64'(awaddr), 64'(addr));
                    chk("awlen", 64'(awlen), 64'(len));
                    chk("awsize", 64'(awsize), 64'(2));
                    chk("awburst", 64'(awburst), 64'(1));
                    chk("aw_id_cache_prot", 64'({awid, awcache, awprot}), 64'(0));
                end
                chk("wvalid", 64'(wvalid), 64'(in_wdata && wr_tvalid));
                chk("wr_tready", 64'(wr_tready), 64'(in_wdata && wready));
                chk("bready", 64'(bready), 64'(in_wresp));
                chk("arvalid", 64'(arvalid), 64'(in_raddr));
                if (in_raddr) begin
                    chk("araddr", 64'(araddr), 64'(addr));
                    chk("arlen", 64'(arlen), 64'(len));
                    chk("arsize", 64'(arsize), 64'(2));
                    chk("arburst", 64'(arburst), 64'(1));
                    chk("ar_id_cache_prot", 64'({arid, arcache, arprot}), 64'(0));
                end
                chk("rready", 64'(rready), 64'(in_rdata && rd_tready));
                chk("rd_tvalid", 64'(rd_tvalid), 64'(in_rdata && rvalid));

                if (cmd_valid && cmd_ready) accepted = 1;
                if (in_waddr) aw_wait++;
                if (awvalid && awready) begin aw_done = 1; aw_hs++; end
                if (wvalid && wready) begin
                    chk("wdata", 64'(wdata), 64'(g_wdata[w_cnt % 256]));
                    chk("wstrb", 64'(wstrb), 64'(4'hF));
                    chk("wlast", 64'(wlast), 64'(w_cnt == len));
                    w_cnt++;
                end
                if (bvalid && bready) begin b_done = 1; done_next = 1; end
                if (arvalid && arready) begin ar_done = 1; ar_hs++; end
                if (rvalid && rready) begin
                    chk("rd_tdata", 64'(rd_tdata), 64'(g_rdata[r_cnt % 256]));
                    chk("rd_tlast", 64'(rd_tlast), 64'(rlast));
                    r_cnt++;
                    if (r_cnt == n_rsend) begin r_done = 1; done_next = 1; end
                end

                @(posedge clk); #1;
                cyc++;
            end
        end

        chk("cmd_completed", 64'(fin), 64'(1));
        if (!rst_hit) begin
            if (wr) begin
                chk("aw_count", 64'(aw_hs), 64'(1));
                chk("w_beats", 64'(w_cnt), 64'(len + 1));
            end else begin
                chk("ar_count", 64'(ar_hs), 64'(1));
                chk("r_beats", 64'(r_cnt), 64'(n_rsend));
            end
        end
    endtask

    initial begin
        bit            rwr;
        int            rlen, rsel, rrl;
        logic [AW-1:0] raddr;

        drive_idle();
        fill_rand();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({awvalid, wvalid, bready, arvalid, rready, cmd_ready,
                              wr_tready, rd_tvalid, done_valid}), 64'(0));
        chk("reset_done_resp", 64'(done_resp), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("ready_before_edge", 64'(cmd_ready), 64'(0));
        @(posedge clk); #1;
        chk("ready_after_edge", 64'(cmd_ready), 64'(1));

        // single write beat
        g_wdata[0] = 32'hA5A5_A5A5;
        do_cmd(1'b1, 32'h100, 0, 0, 0, 2'b00, 1'b0, -1);

        // 16-beat read with periodic rd_tready backpressure
        for (int i = 0; i < 16; i++) begin g_rdata[i] = 32'(i); g_rresp[i] = 2'b00; end
        do_cmd(1'b0, 32'h0, 15, 0, 15, 2'b00, 1'b1, -1);

        // error accumulation across a 4-beat read
        g_rresp[0] = 2'b00; g_rresp[1] = 2'b10; g_rresp[2] = 2'b00; g_rresp[3] = 2'b00;
        do_cmd(1'b0, 32'h40, 3, 0, 3, 2'b00, 1'b0, -1);

        // AWREADY withheld for 10 cycles
        do_cmd(1'b1, 32'h200, 3, 10, 3, 2'b00, 1'b0, -1);

        // early RLAST, then missing RLAST
        do_cmd(1'b0, 32'h80, 7, 0, 3, 2'b00, 1'b0, -1);
        do_cmd(1'b0, 32'hC0, 4, 0, 999, 2'b00, 1'b0, -1);

        // error write response, DECERR read beat
        do_cmd(1'b1, 32'h300, 2, 0, 2, 2'b10, 1'b0, -1);
        g_rresp[1] = 2'b11;
        do_cmd(1'b0, 32'h340, 2, 0, 2, 2'b00, 1'b0, -1);

        // reset in the middle of a write burst, then recover
        do_cmd(1'b1, 32'h400, 7, 0, 7, 2'b00, 1'b0, 2);
        do_cmd(1'b1, 32'h500, 5, 2, 5, 2'b01, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            fill_rand();
            rwr   = 1'($urandom_range(0, 1));
            rlen  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 60) : $urandom_range(0, 15);
            rsel  = $urandom_range(0, 9);
            rrl   = (rsel == 0) ? $urandom_range(0, rlen) : ((rsel == 1) ? 999 : rlen);
            raddr = $urandom();
            raddr[1:0] = 2'b00;
            do_cmd(rwr, raddr, rlen, $urandom_range(0, 3), rrl, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
